// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller and datapath.
package pipeline_pkg;

    localparam int REG_ADDR_W = 3;

    // ADDI x0, x0, 0 -- loaded into IF/ID on a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare between the ID-stage sources and the EX-stage load target.
module hazard_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    // x0 is hard-wired, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing FSM: PC / IF/ID / ID/EX / EX/MEM enables plus perf counters.
//   state    | meaning
//   RUN      | normal flow; branch, load-use and mem wait evaluated each cycle
//   LU_STALL | holding PC and IF/ID, bubbling ID/EX for a load-use hazard
//   MEM_WAIT | data memory busy; whole pipeline frozen
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W   = pipeline_pkg::REG_ADDR_W,
    parameter int LU_STALL_CYC = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_write,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [2:0] LU_LOAD = 3'(LU_STALL_CYC - 1);

    hz_state_t  state, state_nxt;
    logic [2:0] stall_cnt, stall_cnt_nxt;
    logic       load_use;
    logic       flush_hit;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            stall_cnt   <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            if (!pc_write && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_hit && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        flush_hit     = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;

        // MEM_WAIT with mem_busy low falls through to the RUN rules
        if (mem_busy) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_write  = 1'b0;
            stall_cnt_nxt = '0;
            state_nxt     = MEM_WAIT;
        end else if (ex_branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            flush_hit     = 1'b1;
            stall_cnt_nxt = '0;
            state_nxt     = RUN;
        end else if (state == LU_STALL) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            stall_cnt_nxt = (stall_cnt != '0) ? stall_cnt - 3'd1 : 3'd0;
            if (stall_cnt <= 3'd1)
                state_nxt = RUN;
        end else if (load_use) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            stall_cnt_nxt = LU_LOAD;
            state_nxt     = (LU_STALL_CYC > 1) ? LU_STALL : RUN;
        end else begin
            state_nxt = RUN;
        end

        if (!rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-control scoreboard.
module tb_pipeline_hazard_ctrl;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write}
    localparam logic [4:0] RUN_V = 5'b11001;
    localparam logic [4:0] STL_V = 5'b00011;
    localparam logic [4:0] BR_V  = 5'b11111;
    localparam logic [4:0] FRZ_V = 5'b00000;
    localparam logic [4:0] RST_V = 5'b00110;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;

    wire [4:0]  ctl1, ctl3, ctls;
    wire [15:0] sc1, fc1, sc3, fc3;
    wire [3:0]  scs, fcs;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];
    int         who_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .LU_STALL_CYC(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(ctl1[4]), .if_id_write(ctl1[3]), .if_id_flush(ctl1[2]),
        .id_ex_bubble(ctl1[1]), .ex_mem_write(ctl1[0]),
        .stall_count(sc1), .flush_count(fc1));

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .LU_STALL_CYC(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(ctl3[4]), .if_id_write(ctl3[3]), .if_id_flush(ctl3[2]),
        .id_ex_bubble(ctl3[1]), .ex_mem_write(ctl3[0]),
        .stall_count(sc3), .flush_count(fc3));

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .LU_STALL_CYC(1), .CNT_W(4)) duts (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(ctls[4]), .if_id_write(ctls[3]), .if_id_flush(ctls[2]),
        .id_ex_bubble(ctls[1]), .ex_mem_write(ctls[0]),
        .stall_count(scs), .flush_count(fcs));

    function automatic logic [4:0] ctl_of(input int who);
        if (who == 1) return ctl1;
        if (who == 3) return ctl3;
        return ctls;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [2:0] r1, input logic [2:0] r2, input logic u1,
                         input logic u2, input logic [2:0] rd, input logic mr,
                         input logic br, input logic mb);
        @(negedge clk);
        id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; mem_busy = mb;
    endtask

    task automatic step(input string tag, input int who, input logic [4:0] e,
                        input logic [2:0] r1, input logic [2:0] r2, input logic u1,
                        input logic u2, input logic [2:0] rd, input logic mr,
                        input logic br, input logic mb);
        logic [4:0] x;
        int         w;
        drive(r1, r2, u1, u2, rd, mr, br, mb);
        exp_q.push_back(e);
        who_q.push_back(who);
        #2;
        x = exp_q.pop_front();
        w = who_q.pop_front();
        chk(tag, 32'(ctl_of(w)), 32'(x));
    endtask

    task automatic idle(input string tag, input int who, input logic [4:0] e);
        step(tag, who, e, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // load in EX writes x3, ID reads x3 through rs2
    task automatic hz(input string tag, input int who, input logic [4:0] e,
                      input logic br, input logic mb);
        step(tag, who, e, 3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, br, mb);
    endtask

    task automatic do_reset();
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ctl1", 32'(ctl1), 32'(RST_V));
        chk("rst_ctl3", 32'(ctl3), 32'(RST_V));
        chk("rst_sc1", 32'(sc1), 32'd0);
        chk("rst_fc1", 32'(fc1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        idle("post_rst_run", 1, RUN_V);

        hz("lu_rs2", 1, STL_V, 1'b0, 1'b0);
        idle("lu_end", 1, RUN_V);
        chk("lu_sc", 32'(sc1), 32'd1);
        step("lu_x0", 1, RUN_V, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        idle("x0_idle", 1, RUN_V);
        chk("x0_sc", 32'(sc1), 32'd1);
        step("lu_rs1", 1, STL_V, 3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        step("rs1_unused", 1, RUN_V, 3'd5, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        step("not_load", 1, RUN_V, 3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        chk("rs1_sc", 32'(sc1), 32'd2);

        hz("br_over_lu", 1, BR_V, 1'b1, 1'b0);
        idle("br_end", 1, RUN_V);
        chk("br_fc", 32'(fc1), 32'd1);
        chk("br_sc", 32'(sc1), 32'd2);

        do_reset();
        for (int i = 0; i < 4; i++) hz("freeze", 1, FRZ_V, 1'b1, 1'b1);
        hz("release_br", 1, BR_V, 1'b1, 1'b0);
        idle("release_idle", 1, RUN_V);
        chk("sim_sc", 32'(sc1), 32'd4);
        chk("sim_fc", 32'(fc1), 32'd1);
        hz("wait_lu", 1, FRZ_V, 1'b0, 1'b1);
        hz("release_lu", 1, STL_V, 1'b0, 1'b0);
        idle("wait_lu_idle", 1, RUN_V);
        chk("wait_lu_sc", 32'(sc1), 32'd6);

        do_reset();
        hz("lu3_c1", 3, STL_V, 1'b0, 1'b0);
        hz("lu3_c2_br", 3, BR_V, 1'b1, 1'b0);
        idle("lu3_c3_run", 3, RUN_V);
        chk("lu3_abort_sc", 32'(sc3), 32'd1);
        chk("lu3_abort_fc", 32'(fc3), 32'd1);
        hz("lu3_full_c1", 3, STL_V, 1'b0, 1'b0);
        idle("lu3_full_c2", 3, STL_V);
        idle("lu3_full_c3", 3, STL_V);
        idle("lu3_full_end", 3, RUN_V);
        chk("lu3_full_sc", 32'(sc3), 32'd4);

        do_reset();
        for (int i = 0; i < 20; i++) drive(3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        idle("sat_idle", 4, RUN_V);
        chk("sat_scs", 32'(scs), 32'd15);
        chk("sat_sc1", 32'(sc1), 32'd20);

        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("wait_frz", 32'(ctl1), 32'(FRZ_V));
        rst = 1'b0;
        #1;
        chk("wait_rst_ctl", 32'(ctl1), 32'(RST_V));
        chk("wait_rst_scs", 32'(scs), 32'd0);
        chk("wait_rst_sc1", 32'(sc1), 32'd0);
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("wait_rst_run", 32'(ctl1), 32'(RUN_V));

        hz("stall_enter", 3, STL_V, 1'b0, 1'b0);
        idle("stall_mid", 3, STL_V);
        rst = 1'b0;
        #1;
        chk("stall_rst_ctl", 32'(ctl3), 32'(RST_V));
        chk("stall_rst_sc", 32'(sc3), 32'd0);
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("stall_rst_run", 32'(ctl3), 32'(RUN_V));
        idle("stall_rst_run2", 3, RUN_V);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
